code_sender: RTL

- Transmit side of the 4-digit code-lock interface: replays a stored digit sequence onto the 4-bit digit bus that the lock's next-state logic samples every cycle.
- Used by the lab top level and by benches to drive the lock (e.g. code 16'h1469 produces digits 1,4,6,9) without a keypad.
- Sequential block: loads the code on a start request, shifts out one digit per slot, then returns the bus to an idle value.

---
 rtl/code_lock_pkg.sv | 21 ++
 rtl/hold_counter.sv | 28 ++
 rtl/code_sender.sv | 119 +++++++++++
 3 files changed

// File: rtl/code_lock_pkg.sv
// Shared encodings for the code lock and its code sender.
// Holds lock/sender state constants, digit width and the default code.
package code_lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } sndState_e;

  localparam logic [15:0] LOCK_CODE = 16'h1469;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag (hold/debounce/timeout timing).
// Ports: clk_i, rst_ni, load, loadValue, en, zero.
module hold_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (en && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_sender.sv
// Replays a stored code, MS digit first, onto the lock's digit bus.
// Ports: clk_i, rst_ni, start_i, abort_i, code_i -> data_o, valid_o, busy_o, done_o, digit_idx_o.
module code_sender
  import code_lock_pkg::*;
#(
  parameter int         NUM_DIGITS  = 4,
  parameter int         HOLD_CYCLES = 1,
  parameter logic [3:0] IDLE_DIGIT  = 4'd0,
  localparam int        CODE_W      = DIGIT_W * NUM_DIGITS,
  localparam int        IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [3:0]        data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W-1:0]  digit_idx_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  sndState_e         state, stateNext;
  logic [CODE_W-1:0] shiftReg, shiftNext;
  logic [IDX_W-1:0]  idxNext;
  logic              cntLoad;
  logic [CNT_W-1:0]  cntLoadValue;
  logic              holdZero;
  logic [3:0]        dataNext;

  hold_counter #(
    .WIDTH(CNT_W)
  ) uHold (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (cntLoad),
    .loadValue(cntLoadValue),
    .en       (state == SEND),
    .zero     (holdZero)
  );

  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    idxNext      = digit_idx_o;
    cntLoad      = 1'b0;
    cntLoadValue = HOLD_LOAD;
    unique case (state)
      IDLE: begin
        // abort alongside start suppresses the start
        if (start_i && !abort_i) begin
          stateNext = SEND;
          shiftNext = code_i;
          idxNext   = '0;
          cntLoad   = 1'b1;
        end
      end
      SEND: begin
        if (abort_i) begin
          stateNext    = IDLE;
          idxNext      = '0;
          cntLoad      = 1'b1;
          cntLoadValue = '0;
        end else if (holdZero) begin
          shiftNext = shiftReg << DIGIT_W;
          if (digit_idx_o == LAST_IDX) begin
            stateNext = DONE;
            idxNext   = '0;
          end else begin
            idxNext = digit_idx_o + IDX_W'(1);
            cntLoad = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
    endcase
  end

  // outputs are decoded from next state so they leave flops directly
  always_comb begin
    dataNext = IDLE_DIGIT;
    if (stateNext == SEND) begin
      dataNext = shiftNext[CODE_W-1 -: DIGIT_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      shiftReg    <= '0;
      digit_idx_o <= '0;
      data_o      <= IDLE_DIGIT;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= stateNext;
      shiftReg    <= shiftNext;
      digit_idx_o <= idxNext;
      data_o      <= dataNext;
      valid_o     <= (stateNext == SEND);
      busy_o      <= (stateNext != IDLE);
      done_o      <= (stateNext == DONE);
    end
  end

endmodule
